noc_msg_tx: RTL and testbench

NOC_MSG_TX -- requirements
Module: noc_msg_tx

---
 rtl/noc_msg_tx.sv | 188 ++++++++++++++++++
 tb/tb_noc_msg_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_msg_tx.sv
// Packetizes a request plus buffered payload words into NoC flits on one
// virtual channel, presenting each flit from a registered output stage.
module noc_msg_tx #(
  parameter int         NOC_FLIT_DATA_WIDTH = 32,
  parameter int         NOC_FLIT_TYPE_WIDTH = 2,
  parameter int         VCHANNELS           = 3,
  parameter int         MAX_LEN             = 8,
  parameter logic [4:0] SRC_ID              = 5'd0
) (
  input  logic                                           clk,
  input  logic                                           rst_sys_n,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [1:0]                                     req_vc,
  input  logic [4:0]                                     req_dest,
  input  logic [2:0]                                     req_class,
  input  logic [3:0]                                     req_len,
  input  logic                                           data_valid,
  output logic                                           data_ready,
  input  logic [NOC_FLIT_DATA_WIDTH-1:0]                 data,
  output logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] noc_out_flit,
  output logic [VCHANNELS-1:0]                           noc_out_valid,
  input  logic [VCHANNELS-1:0]                           noc_out_ready,
  output logic                                           busy,
  output logic                                           pkt_sent
);

  localparam int DW    = NOC_FLIT_DATA_WIDTH;
  localparam int TW    = NOC_FLIT_TYPE_WIDTH;
  localparam int FW    = TW + DW;
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  localparam logic [TW-1:0]    TYPE_PAY    = TW'(2'b00);
  localparam logic [TW-1:0]    TYPE_HEAD   = TW'(2'b01);
  localparam logic [TW-1:0]    TYPE_LAST   = TW'(2'b10);
  localparam logic [TW-1:0]    TYPE_SINGLE = TW'(2'b11);
  localparam logic [3:0]       LEN_MAX     = 4'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        flit_q, flit_d;
  logic [VCHANNELS-1:0] valid_q, valid_d;
  logic [VCHANNELS-1:0] vcMask_q, vcMask_d;
  logic [3:0]           remLoad_q, remLoad_d;
  logic                 pktSent_q, pktSent_d;

  logic [DW-1:0]        mem_q [MAX_LEN];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 fifoFull, fifoEmpty, push, pop, loadWord;
  logic                 xfer, flitIsLast;
  logic [3:0]           reqLenSat;
  logic [VCHANNELS-1:0] reqVcMask;
  logic [DW-1:0]        hdrData;

  assign fifoFull   = (count_q == CNT_FULL);
  assign fifoEmpty  = (count_q == '0);
  assign push       = data_valid && !fifoFull;
  assign xfer       = |(valid_q & noc_out_ready);
  assign flitIsLast = (flit_q[FW-1:DW] == TYPE_LAST);
  assign reqLenSat  = (req_len > LEN_MAX) ? LEN_MAX : req_len;
  assign hdrData    = {req_dest, req_class, SRC_ID, {(DW-13){1'b0}}};

  // Out-of-range channel numbers fall back to VC 0.
  always_comb begin
    reqVcMask = '0;
    for (int i = 0; i < VCHANNELS; i++) begin
      if (int'(req_vc) == i) reqVcMask[i] = 1'b1;
    end
    if (reqVcMask == '0) reqVcMask[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= IDLE;
      flit_q    <= '0;
      valid_q   <= '0;
      vcMask_q  <= '0;
      remLoad_q <= '0;
      pktSent_q <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      flit_q    <= flit_d;
      valid_q   <= valid_d;
      vcMask_q  <= vcMask_d;
      remLoad_q <= remLoad_d;
      pktSent_q <= pktSent_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= data;
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = HDR;
      HDR:     if (xfer) state_d = (remLoad_q == '0) ? IDLE : PAYLOAD;
      PAYLOAD: if (xfer && flitIsLast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A payload word is popped as it moves into the output register, which
  // refills on the same edge the previous flit leaves to keep 1 flit/cycle.
  always_comb begin
    flit_d    = flit_q;
    valid_d   = valid_q;
    vcMask_d  = vcMask_q;
    remLoad_d = remLoad_q;
    pktSent_d = 1'b0;
    pop       = 1'b0;
    loadWord  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          vcMask_d  = reqVcMask;
          remLoad_d = reqLenSat;
          valid_d   = reqVcMask;
          flit_d    = {(reqLenSat == '0) ? TYPE_SINGLE : TYPE_HEAD, hdrData};
        end
      end
      HDR: begin
        if (xfer) begin
          if (remLoad_q == '0) begin
            valid_d   = '0;
            pktSent_d = 1'b1;
          end else begin
            loadWord = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (xfer && flitIsLast) begin
          valid_d   = '0;
          pktSent_d = 1'b1;
        end else if (xfer || (valid_q == '0)) begin
          loadWord = 1'b1;
        end
      end
      default: ;
    endcase
    if (loadWord) begin
      if (!fifoEmpty && (remLoad_q != '0)) begin
        pop       = 1'b1;
        remLoad_d = remLoad_q - 4'd1;
        valid_d   = vcMask_q;
        flit_d    = {(remLoad_q == 4'd1) ? TYPE_LAST : TYPE_PAY, mem_q[rdPtr_q]};
      end else begin
        valid_d = '0;
      end
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign data_ready    = !fifoFull;
  assign noc_out_flit  = flit_q;
  assign noc_out_valid = valid_q;
  assign pkt_sent      = pktSent_q;

endmodule

// File: tb/tb_noc_msg_tx.sv
// Directed bench for noc_msg_tx: single, multi-word, backpressure, full FIFO,
// mid-packet reset and payload starvation scenarios.
module tb_noc_msg_tx;

  logic        clk = 1'b0;
  logic        rst_sys_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_vc;
  logic [4:0]  req_dest;
  logic [2:0]  req_class;
  logic [3:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic [33:0] noc_out_flit;
  logic [2:0]  noc_out_valid;
  logic [2:0]  noc_out_ready;
  logic        busy;
  logic        pkt_sent;

  int testsRun = 0;
  int testsFailed = 0;

  noc_msg_tx #(
    .NOC_FLIT_DATA_WIDTH(32),
    .NOC_FLIT_TYPE_WIDTH(2),
    .VCHANNELS(3),
    .MAX_LEN(8),
    .SRC_ID(5'd0)
  ) dut (
    .clk(clk),
    .rst_sys_n(rst_sys_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_vc(req_vc),
    .req_dest(req_dest),
    .req_class(req_class),
    .req_len(req_len),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data(data),
    .noc_out_flit(noc_out_flit),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .busy(busy),
    .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] vc, input logic [4:0] dest,
                               input logic [2:0] cls, input logic [3:0] len);
    req_valid = 1'b1;
    req_vc    = vc;
    req_dest  = dest;
    req_class = cls;
    req_len   = len;
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    repeat (2) tick();
    testsRun++;
    if (noc_out_valid !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 000", noc_out_valid); end
    testsRun++;
    if (noc_out_flit !== 34'h0) begin testsFailed++; $display("[TB] FAIL reset_flit: got %h expected 0", noc_out_flit); end
    testsRun++;
    if (busy !== 1'b0 || pkt_sent !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy_sent: got busy=%b sent=%b expected 0 0", busy, pkt_sent); end
    testsRun++;
    if (data_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_data_ready: got %b expected 1", data_ready); end
    rst_sys_n = 1'b1;
    tick();
    testsRun++;
    if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_single();
    noc_out_ready = 3'b010;
    applyStimulus(2'd1, 5'd3, 3'd2, 4'd0);
    tick();
    req_valid = 1'b0;
    testsRun++;
    if (noc_out_valid !== 3'b010 || noc_out_flit !== 34'h3_1A00_0000) begin
      testsFailed++; $display("[TB] FAIL single_flit: got valid=%b flit=%h expected valid=010 flit=31a000000", noc_out_valid, noc_out_flit);
    end
    testsRun++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy: got req_ready=%b busy=%b expected 0 1", req_ready, busy); end
    tick();
    testsRun++;
    if (pkt_sent !== 1'b1 || noc_out_valid !== 3'b000 || busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL single_done: got sent=%b valid=%b busy=%b expected 1 000 0", pkt_sent, noc_out_valid, busy);
    end
    tick();
    testsRun++;
    if (pkt_sent !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_pulse_width: got %b expected 0", pkt_sent); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] expFlit [4];
    expFlit[0] = 34'h1_2900_0000;
    expFlit[1] = 34'h0_0000_000A;
    expFlit[2] = 34'h0_0000_000B;
    expFlit[3] = 34'h2_0000_000C;
    data_valid = 1'b1;
    data = 32'hA; tick();
    data = 32'hB; tick();
    data = 32'hC; tick();
    data_valid = 1'b0;
    noc_out_ready = 3'b001;
    applyStimulus(2'd0, 5'd5, 3'd1, 4'd3);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (noc_out_valid !== 3'b001 || noc_out_flit !== expFlit[i]) begin
        testsFailed++; $display("[TB] FAIL b2b_flit%0d: got valid=%b flit=%h expected valid=001 flit=%h", i, noc_out_valid, noc_out_flit, expFlit[i]);
      end
      tick();
    end
    testsRun++;
    if (noc_out_valid !== 3'b000 || pkt_sent !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL b2b_done: got valid=%b sent=%b expected 000 1", noc_out_valid, pkt_sent);
    end
  endtask

  task automatic test_backpressure();
    data_valid = 1'b1;
    data = 32'h11; tick();
    data = 32'h22; tick();
    data = 32'h33; tick();
    data_valid = 1'b0;
    noc_out_ready = 3'b001;
    applyStimulus(2'd0, 5'd5, 3'd1, 4'd3);
    tick();
    req_valid = 1'b0;
    testsRun++;
    if (noc_out_flit !== 34'h1_2900_0000) begin testsFailed++; $display("[TB] FAIL bp_header: got %h expected 129000000", noc_out_flit); end
    tick();
    noc_out_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h0_0000_0011) begin
        testsFailed++; $display("[TB] FAIL bp_hold%0d: got valid=%b flit=%h expected valid=001 flit=000000011", i, noc_out_valid, noc_out_flit);
      end
      tick();
    end
    noc_out_ready = 3'b001;
    testsRun++;
    if (noc_out_flit !== 34'h0_0000_0011) begin testsFailed++; $display("[TB] FAIL bp_release: got %h expected 000000011", noc_out_flit); end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h0_0000_0022) begin
      testsFailed++; $display("[TB] FAIL bp_second: got valid=%b flit=%h expected valid=001 flit=000000022", noc_out_valid, noc_out_flit);
    end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h2_0000_0033) begin
      testsFailed++; $display("[TB] FAIL bp_last: got valid=%b flit=%h expected valid=001 flit=200000033", noc_out_valid, noc_out_flit);
    end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b000 || pkt_sent !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL bp_done: got valid=%b sent=%b expected 000 1", noc_out_valid, pkt_sent);
    end
  endtask

  task automatic test_fifo_full();
    logic [33:0] expFlit;
    logic [31:0] base;
    logic [33:0] hdr;
    for (int pkt = 0; pkt < 2; pkt++) begin
      base = (pkt == 0) ? 32'h100 : 32'h200;
      hdr  = (pkt == 0) ? 34'h1_FF00_0000 : 34'h1_5400_0000;
      data_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        data = base + 32'(i);
        testsRun++;
        if (data_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_ready_p%0d_w%0d: got %b expected 1", pkt, i, data_ready); end
        tick();
      end
      testsRun++;
      if (data_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_after8_p%0d: got %b expected 0", pkt, data_ready); end
      if (pkt == 0) begin
        data = 32'hDEAD;
        tick();
        testsRun++;
        if (data_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ninth: got %b expected 0", data_ready); end
      end
      data_valid = 1'b0;
      noc_out_ready = 3'b100;
      if (pkt == 0) applyStimulus(2'd2, 5'd31, 3'd7, 4'd15);
      else          applyStimulus(2'd2, 5'd10, 3'd4, 4'd8);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (i == 0)      expFlit = hdr;
        else if (i == 8) expFlit = {2'b10, base + 32'd7};
        else             expFlit = {2'b00, base + 32'(i - 1)};
        testsRun++;
        if (noc_out_valid !== 3'b100 || noc_out_flit !== expFlit) begin
          testsFailed++; $display("[TB] FAIL full_flit_p%0d_%0d: got valid=%b flit=%h expected valid=100 flit=%h", pkt, i, noc_out_valid, noc_out_flit, expFlit);
        end
        tick();
      end
      testsRun++;
      if (noc_out_valid !== 3'b000 || pkt_sent !== 1'b1 || data_ready !== 1'b1) begin
        testsFailed++; $display("[TB] FAIL full_done_p%0d: got valid=%b sent=%b data_ready=%b expected 000 1 1", pkt, noc_out_valid, pkt_sent, data_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    data_valid = 1'b1;
    data = 32'h31; tick();
    data = 32'h32; tick();
    data = 32'h33; tick();
    data_valid = 1'b0;
    noc_out_ready = 3'b001;
    applyStimulus(2'd0, 5'd1, 3'd1, 4'd3);
    tick();
    req_valid = 1'b0;
    testsRun++;
    if (noc_out_flit !== 34'h1_0900_0000) begin testsFailed++; $display("[TB] FAIL rmid_header: got %h expected 109000000", noc_out_flit); end
    tick();
    tick();
    testsRun++;
    if (noc_out_flit !== 34'h0_0000_0032) begin testsFailed++; $display("[TB] FAIL rmid_second: got %h expected 000000032", noc_out_flit); end
    rst_sys_n = 1'b0;
    #1;
    testsRun++;
    if (noc_out_valid !== 3'b000 || noc_out_flit !== 34'h0 || busy !== 1'b0 || data_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rmid_cleared: got valid=%b flit=%h busy=%b data_ready=%b expected 000 0 0 1", noc_out_valid, noc_out_flit, busy, data_ready);
    end
    tick();
    rst_sys_n = 1'b1;
    tick();
    testsRun++;
    if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_req_ready: got %b expected 1", req_ready); end
    data_valid = 1'b1;
    data = 32'h77;
    tick();
    data_valid = 1'b0;
    noc_out_ready = 3'b010;
    applyStimulus(2'd1, 5'd2, 3'd3, 4'd1);
    tick();
    req_valid = 1'b0;
    testsRun++;
    if (noc_out_valid !== 3'b010 || noc_out_flit !== 34'h1_1300_0000) begin
      testsFailed++; $display("[TB] FAIL rmid_new_header: got valid=%b flit=%h expected valid=010 flit=113000000", noc_out_valid, noc_out_flit);
    end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b010 || noc_out_flit !== 34'h2_0000_0077) begin
      testsFailed++; $display("[TB] FAIL rmid_new_last: got valid=%b flit=%h expected valid=010 flit=200000077", noc_out_valid, noc_out_flit);
    end
    tick();
    testsRun++;
    if (pkt_sent !== 1'b1 || noc_out_valid !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL rmid_new_done: got sent=%b valid=%b expected 1 000", pkt_sent, noc_out_valid);
    end
  endtask

  task automatic test_starvation();
    noc_out_ready = 3'b001;
    applyStimulus(2'd3, 5'd1, 3'd0, 4'd2);
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h1_0800_0000) begin
      testsFailed++; $display("[TB] FAIL starve_header: got valid=%b flit=%h expected valid=001 flit=108000000", noc_out_valid, noc_out_flit);
    end
    // A second request stays asserted to show it is held off mid-packet.
    applyStimulus(2'd2, 5'd9, 3'd5, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (noc_out_valid !== 3'b000 || busy !== 1'b1 || req_ready !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL starve_wait%0d: got valid=%b busy=%b req_ready=%b expected 000 1 0", i, noc_out_valid, busy, req_ready);
      end
    end
    req_valid = 1'b0;
    data_valid = 1'b1;
    data = 32'h55;
    tick();
    data_valid = 1'b0;
    testsRun++;
    if (noc_out_valid !== 3'b000) begin testsFailed++; $display("[TB] FAIL starve_push: got %b expected 000", noc_out_valid); end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h0_0000_0055) begin
      testsFailed++; $display("[TB] FAIL starve_first: got valid=%b flit=%h expected valid=001 flit=000000055", noc_out_valid, noc_out_flit);
    end
    data_valid = 1'b1;
    data = 32'h66;
    tick();
    data_valid = 1'b0;
    testsRun++;
    if (noc_out_valid !== 3'b000) begin testsFailed++; $display("[TB] FAIL starve_gap: got %b expected 000", noc_out_valid); end
    tick();
    testsRun++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h2_0000_0066) begin
      testsFailed++; $display("[TB] FAIL starve_last: got valid=%b flit=%h expected valid=001 flit=200000066", noc_out_valid, noc_out_flit);
    end
    tick();
    testsRun++;
    if (pkt_sent !== 1'b1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL starve_done: got sent=%b busy=%b expected 1 0", pkt_sent, busy); end
  endtask

  initial begin
    rst_sys_n     = 1'b0;
    req_valid     = 1'b0;
    req_vc        = 2'd0;
    req_dest      = 5'd0;
    req_class     = 3'd0;
    req_len       = 4'd0;
    data_valid    = 1'b0;
    data          = 32'h0;
    noc_out_ready = 3'b000;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fifo_full();
    test_reset_mid();
    test_starvation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
